aib_calib_master_fsm: RTL and testbench



---
 rtl/aib_calib_master_fsm_if.sv | 48 ++++
 rtl/aib_calib_master_fsm.sv | 149 ++++++++++++++
 tb/tb_aib_calib_master_fsm.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aib_calib_master_fsm_if.sv
// Handshake bundle between the AIB calibration master, the Avalon config
// sequencer and the far-die slave calibration FSM.
// The master modport is the calibration sequencer's view.
// The slave modport is the view of everything the sequencer talks to.
interface aib_calib_master_fsm_if #(
   parameter int TOTAL_CHNL_NUM = 24,
   parameter int MAX_RETRY      = 3
);
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   logic                      cfg_start;
   logic                      cfg_done;
   logic [TOTAL_CHNL_NUM-1:0] fs_mac_rdy;
   logic [TOTAL_CHNL_NUM-1:0] sl_rx_dcc_dll_lock_req;
   logic [TOTAL_CHNL_NUM-1:0] sl_tx_dcc_dll_lock_req;
   logic [TOTAL_CHNL_NUM-1:0] sl_rx_transfer_en;
   logic [TOTAL_CHNL_NUM-1:0] sl_tx_transfer_en;
   logic                      i_conf_done;
   logic [TOTAL_CHNL_NUM-1:0] ns_mac_rdy;
   logic [TOTAL_CHNL_NUM-1:0] ns_adapter_rstn;
   logic [TOTAL_CHNL_NUM-1:0] ms_rx_dcc_dll_lock_req;
   logic [TOTAL_CHNL_NUM-1:0] ms_tx_dcc_dll_lock_req;
   logic [TOTAL_CHNL_NUM-1:0] ms_rx_transfer_en;
   logic [TOTAL_CHNL_NUM-1:0] ms_tx_transfer_en;
   logic                      calib_done;
   logic                      calib_fail;
   logic [RETRY_W-1:0]        retry_cnt;

   modport master (
      output cfg_start, i_conf_done, ns_mac_rdy, ns_adapter_rstn,
             ms_rx_dcc_dll_lock_req, ms_tx_dcc_dll_lock_req,
             ms_rx_transfer_en, ms_tx_transfer_en,
             calib_done, calib_fail, retry_cnt,
      input  cfg_done, fs_mac_rdy,
             sl_rx_dcc_dll_lock_req, sl_tx_dcc_dll_lock_req,
             sl_rx_transfer_en, sl_tx_transfer_en
   );

   modport slave (
      input  cfg_start, i_conf_done, ns_mac_rdy, ns_adapter_rstn,
             ms_rx_dcc_dll_lock_req, ms_tx_dcc_dll_lock_req,
             ms_rx_transfer_en, ms_tx_transfer_en,
             calib_done, calib_fail, retry_cnt,
      output cfg_done, fs_mac_rdy,
             sl_rx_dcc_dll_lock_req, sl_tx_dcc_dll_lock_req,
             sl_rx_transfer_en, sl_tx_transfer_en
   );
endinterface

// File: rtl/aib_calib_master_fsm.sv
// Master-side AIB link calibration sequencer.
// Sequence: config pass, wait for the far-side MAC, DCC/DLL lock handshake,
// transfer-enable handshake, link up. Link loss always goes through a
// request-low backoff before the lock handshake is retried.
// Optional feature macro CALIB_MASTER_TIMEOUT_EN:
//   defined   - handshake waits time out after TIMEOUT_CYCLES, bounded retries,
//               sticky failure state.
//   undefined - handshake waits are unbounded; calib_fail/retry_cnt stay 0.
// All outputs are registered and decoded from the next state, so a state's
// output values appear in the first cycle that state is held.
module aib_calib_master_fsm #(
   parameter int TOTAL_CHNL_NUM = 24,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int MAX_RETRY      = 3,
   parameter int BACKOFF_CYCLES = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   aib_calib_master_fsm_if.master bus
);
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int CNT_MAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [TOTAL_CHNL_NUM-1:0] ALL_ONES = '1;

   typedef enum logic [3:0] {
      S_IDLE, S_CFG_START, S_CFG_WAIT, S_WAIT_FS_RDY, S_WAIT_LOCK,
      S_WAIT_XFER, S_DONE, S_BACKOFF, S_FAIL
   } state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   wait_cnt;
   logic [RETRY_W-1:0] retry_nx;
   logic               fs_all, lock_all, xfer_all, backoff_end;
   logic               cfg_start_d, conf_d, lock_d, rstn_d, xfer_d, fail_d;

   assign fs_all      = &bus.fs_mac_rdy;
   assign lock_all    = (&bus.sl_rx_dcc_dll_lock_req) & (&bus.sl_tx_dcc_dll_lock_req);
   assign xfer_all    = (&bus.sl_rx_transfer_en) & (&bus.sl_tx_transfer_en);
   assign backoff_end = (wait_cnt == CNT_W'(BACKOFF_CYCLES - 1));

`ifdef CALIB_MASTER_TIMEOUT_EN
   logic timeout_hit;
   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   // Next-state and retry bookkeeping; a satisfied exit condition beats a timeout.
   always_comb begin
      state_nx = state;
`ifdef CALIB_MASTER_TIMEOUT_EN
      retry_nx = bus.retry_cnt;
`else
      retry_nx = '0;
`endif
      case (state)
         S_IDLE:        state_nx = S_CFG_START;
         S_CFG_START:   state_nx = S_CFG_WAIT;
         S_CFG_WAIT:    if (bus.cfg_done) state_nx = S_WAIT_FS_RDY;
         S_WAIT_FS_RDY: if (fs_all) state_nx = S_WAIT_LOCK;
         S_WAIT_LOCK: begin
            if (lock_all) state_nx = S_WAIT_XFER;
`ifdef CALIB_MASTER_TIMEOUT_EN
            else if (timeout_hit) state_nx = S_BACKOFF;
`endif
         end
         S_WAIT_XFER: begin
            if (xfer_all) state_nx = S_DONE;
`ifdef CALIB_MASTER_TIMEOUT_EN
            else if (timeout_hit) state_nx = S_BACKOFF;
`endif
         end
         S_DONE:        if (!(lock_all && xfer_all)) state_nx = S_BACKOFF;
         S_BACKOFF: begin
            if (backoff_end) begin
`ifdef CALIB_MASTER_TIMEOUT_EN
               if (bus.retry_cnt == RETRY_W'(MAX_RETRY)) begin
                  state_nx = S_FAIL;
               end else begin
                  state_nx = S_WAIT_LOCK;
                  retry_nx = bus.retry_cnt + 1'b1;
               end
`else
               state_nx = S_WAIT_LOCK;
`endif
            end
         end
         S_FAIL:        state_nx = S_FAIL;
         default:       state_nx = S_IDLE;
      endcase
   end

   // State register and per-state dwell counter, cleared on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state_nx != state) begin
            wait_cnt <= '0;
         end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   // Output decode from the state about to be entered.
   always_comb begin
      cfg_start_d = (state_nx == S_CFG_START);
      conf_d      = state_nx inside {S_WAIT_FS_RDY, S_WAIT_LOCK, S_WAIT_XFER, S_DONE, S_BACKOFF};
      lock_d      = state_nx inside {S_WAIT_LOCK, S_WAIT_XFER, S_DONE};
      rstn_d      = state_nx inside {S_WAIT_XFER, S_DONE};
      xfer_d      = (state_nx == S_DONE);
`ifdef CALIB_MASTER_TIMEOUT_EN
      fail_d      = (state_nx == S_FAIL);
`else
      fail_d      = 1'b0;
`endif
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.cfg_start              <= 1'b0;
         bus.i_conf_done            <= 1'b0;
         bus.ns_mac_rdy             <= '0;
         bus.ns_adapter_rstn        <= '0;
         bus.ms_rx_dcc_dll_lock_req <= '0;
         bus.ms_tx_dcc_dll_lock_req <= '0;
         bus.ms_rx_transfer_en      <= '0;
         bus.ms_tx_transfer_en      <= '0;
         bus.calib_done             <= 1'b0;
         bus.calib_fail             <= 1'b0;
         bus.retry_cnt              <= '0;
      end else begin
         bus.cfg_start              <= cfg_start_d;
         bus.i_conf_done            <= conf_d;
         bus.ns_mac_rdy             <= conf_d ? ALL_ONES : '0;
         bus.ns_adapter_rstn        <= rstn_d ? ALL_ONES : '0;
         bus.ms_rx_dcc_dll_lock_req <= lock_d ? ALL_ONES : '0;
         bus.ms_tx_dcc_dll_lock_req <= lock_d ? ALL_ONES : '0;
         bus.ms_rx_transfer_en      <= xfer_d ? ALL_ONES : '0;
         bus.ms_tx_transfer_en      <= xfer_d ? ALL_ONES : '0;
         bus.calib_done             <= xfer_d;
         bus.calib_fail             <= fail_d;
         bus.retry_cnt              <= retry_nx;
      end
   end
endmodule

// File: tb/tb_aib_calib_master_fsm.sv
// Self-checking bench for aib_calib_master_fsm.
// A phase-level model of the link bring-up predicts every output on every
// cycle; directed scenarios add literal cycle counts and values.
// Cycle k below means the k-th rising clock edge after rst_n is released.
// Follows the CALIB_MASTER_TIMEOUT_EN setting of the build.
module tb_aib_calib_master_fsm;
   localparam int CHN     = 24;
   localparam int TMO     = 1024;
   localparam int RETRIES = 3;
   localparam int BACKOFF = 16;
   localparam logic [CHN-1:0] ONES = 24'hFFFFFF;
`ifdef CALIB_MASTER_TIMEOUT_EN
   localparam bit TO_EN           = 1'b1;
   localparam int RETRY_AFTER_DROP = 1;
`else
   localparam bit TO_EN           = 1'b0;
   localparam int RETRY_AFTER_DROP = 0;
`endif

   // Model phases of the link bring-up
   localparam int M_BOOT = 0, M_PULSE = 1, M_CFGWAIT = 2, M_FSWAIT = 3, M_LOCKWAIT = 4;
   localparam int M_XFERWAIT = 5, M_UP = 6, M_PAUSE = 7, M_DEAD = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;

   aib_calib_master_fsm_if #(.TOTAL_CHNL_NUM(CHN), .MAX_RETRY(RETRIES)) bus ();

   aib_calib_master_fsm #(
      .TOTAL_CHNL_NUM(CHN), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(RETRIES), .BACKOFF_CYCLES(BACKOFF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   // Model state: phase, 1-based cycle within the phase, retries used
   int   m_phase = M_BOOT;
   int   m_held  = 1;
   int   m_tries = 0;
   int   m_next;
   logic sl_lock_all, sl_xfer_all;
   logic exp_pulse, exp_conf, exp_lock, exp_rstn, exp_up, exp_dead;

   assign sl_lock_all = (bus.sl_rx_dcc_dll_lock_req == ONES) && (bus.sl_tx_dcc_dll_lock_req == ONES);
   assign sl_xfer_all = (bus.sl_rx_transfer_en == ONES) && (bus.sl_tx_transfer_en == ONES);

   // Model: where the link goes next from what the slave side shows now
   always_comb begin
      m_next = m_phase;
      case (m_phase)
         M_BOOT:     m_next = M_PULSE;
         M_PULSE:    m_next = M_CFGWAIT;
         M_CFGWAIT:  if (bus.cfg_done) m_next = M_FSWAIT;
         M_FSWAIT:   if (bus.fs_mac_rdy == ONES) m_next = M_LOCKWAIT;
         M_LOCKWAIT: if (sl_lock_all) m_next = M_XFERWAIT;
                     else if (TO_EN && m_held == TMO) m_next = M_PAUSE;
         M_XFERWAIT: if (sl_xfer_all) m_next = M_UP;
                     else if (TO_EN && m_held == TMO) m_next = M_PAUSE;
         M_UP:       if (!(sl_lock_all && sl_xfer_all)) m_next = M_PAUSE;
         M_PAUSE:    if (m_held == BACKOFF) m_next = (TO_EN && m_tries == RETRIES) ? M_DEAD : M_LOCKWAIT;
         default:    m_next = m_phase;
      endcase
   end

   // Model: advance one cycle, restart on reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= M_BOOT;
         m_held  <= 1;
         m_tries <= 0;
      end else begin
         m_phase <= m_next;
         m_held  <= (m_next == m_phase) ? m_held + 1 : 1;
         if (TO_EN && m_phase == M_PAUSE && m_next == M_LOCKWAIT) m_tries <= m_tries + 1;
      end
   end

   // Model: outputs expected while in each phase
   always_comb begin
      exp_pulse = (m_phase == M_PULSE);
      exp_conf  = (m_phase >= M_FSWAIT) && (m_phase <= M_PAUSE);
      exp_lock  = (m_phase >= M_LOCKWAIT) && (m_phase <= M_UP);
      exp_rstn  = (m_phase == M_XFERWAIT) || (m_phase == M_UP);
      exp_up    = (m_phase == M_UP);
      exp_dead  = (m_phase == M_DEAD);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      checkOutput("cfg_start",    32'(bus.cfg_start),   32'(exp_pulse));
      checkOutput("i_conf_done",  32'(bus.i_conf_done), 32'(exp_conf));
      checkOutput("ns_mac_rdy",   32'(bus.ns_mac_rdy),  exp_conf ? 32'(ONES) : 32'd0);
      checkOutput("ns_adapter_rstn", 32'(bus.ns_adapter_rstn), exp_rstn ? 32'(ONES) : 32'd0);
      checkOutput("ms_rx_lock_req", 32'(bus.ms_rx_dcc_dll_lock_req), exp_lock ? 32'(ONES) : 32'd0);
      checkOutput("ms_tx_lock_req", 32'(bus.ms_tx_dcc_dll_lock_req), exp_lock ? 32'(ONES) : 32'd0);
      checkOutput("ms_rx_xfer_en", 32'(bus.ms_rx_transfer_en), exp_up ? 32'(ONES) : 32'd0);
      checkOutput("ms_tx_xfer_en", 32'(bus.ms_tx_transfer_en), exp_up ? 32'(ONES) : 32'd0);
      checkOutput("calib_done",   32'(bus.calib_done),  32'(exp_up));
      checkOutput("calib_fail",   32'(bus.calib_fail),  32'(exp_dead));
      checkOutput("retry_cnt",    32'(bus.retry_cnt),   32'(m_tries));
   end

   task automatic applyStimulus(input logic cfg, input logic [CHN-1:0] fs,
                                input logic [CHN-1:0] rx_lock, input logic [CHN-1:0] tx_lock,
                                input logic [CHN-1:0] rx_xfer, input logic [CHN-1:0] tx_xfer);
      bus.cfg_done               = cfg;
      bus.fs_mac_rdy             = fs;
      bus.sl_rx_dcc_dll_lock_req = rx_lock;
      bus.sl_tx_dcc_dll_lock_req = tx_lock;
      bus.sl_rx_transfer_en      = rx_xfer;
      bus.sl_tx_transfer_en      = tx_xfer;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
   endtask

   // Counts cfg_start pulses and first lock/done cycles over 10 cycles after release
   task automatic checkBringUp(input string tag);
      int starts, first_start, first_lock, first_up;
      starts = 0; first_start = -1; first_lock = -1; first_up = -1;
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         if (bus.cfg_start) begin
            starts++;
            if (first_start < 0) first_start = k;
         end
         if (first_lock < 0 && bus.ms_rx_dcc_dll_lock_req == ONES) first_lock = k;
         if (first_up < 0 && bus.calib_done) first_up = k;
      end
      checkOutput({tag, "_cfg_start_pulses"}, 32'(starts), 32'd1);
      checkOutput({tag, "_cfg_start_cycle"},  32'(first_start), 32'd1);
      checkOutput({tag, "_lock_req_cycle"},   32'(first_lock), 32'd4);
      checkOutput({tag, "_calib_done_cycle"}, 32'(first_up), 32'd6);
   endtask

   initial begin
      int waited, high_run, low_run, relink;
      applyStimulus(1'b1, ONES, ONES, ONES, ONES, ONES);
      #1 rst_n = 1'b0;

      $display("[TB] scenario: all inputs high after reset");
      resetDut();
      checkBringUp("up");
      checkOutput("up_ms_tx_xfer_en", 32'(bus.ms_tx_transfer_en), 32'h00FFFFFF);
      checkOutput("up_ms_rx_lock_req", 32'(bus.ms_rx_dcc_dll_lock_req), 32'h00FFFFFF);
      checkOutput("up_adapter_rstn", 32'(bus.ns_adapter_rstn), 32'h00FFFFFF);

      $display("[TB] scenario: partial far-side MAC ready");
      applyStimulus(1'b1, 24'hFFFFFE, ONES, ONES, ONES, ONES);
      resetDut();
      tick(100);
      checkOutput("fs_partial_lock_req", 32'(bus.ms_tx_dcc_dll_lock_req), 32'd0);
      checkOutput("fs_partial_conf_done", 32'(bus.i_conf_done), 32'd1);
      applyStimulus(1'b1, ONES, ONES, ONES, ONES, ONES);
      tick(1);
      checkOutput("fs_full_lock_req", 32'(bus.ms_tx_dcc_dll_lock_req), 32'h00FFFFFF);

`ifdef CALIB_MASTER_TIMEOUT_EN
      $display("[TB] scenario: slave lock never arrives");
      applyStimulus(1'b1, ONES, '0, '0, ONES, ONES);
      resetDut();
      for (int a = 0; a <= RETRIES; a++) begin
         waited = 0;
         while (bus.ms_tx_dcc_dll_lock_req != ONES && waited < 200) begin
            tick(1);
            waited++;
         end
         checkOutput("to_attempt_started", 32'(waited < 200), 32'd1);
         checkOutput("to_retry_cnt", 32'(bus.retry_cnt), 32'(a));
         high_run = 0;
         while (bus.ms_tx_dcc_dll_lock_req == ONES && high_run < 2000) begin
            high_run++;
            tick(1);
         end
         checkOutput("to_req_high_cycles", 32'(high_run), 32'd1024);
         low_run = 0;
         while (bus.ms_tx_dcc_dll_lock_req == '0 && !bus.calib_fail && low_run < 200) begin
            low_run++;
            tick(1);
         end
         checkOutput("to_req_low_cycles", 32'(low_run), 32'd16);
      end
      checkOutput("to_calib_fail", 32'(bus.calib_fail), 32'd1);
      checkOutput("to_final_retry", 32'(bus.retry_cnt), 32'd3);
      applyStimulus(1'b1, ONES, ONES, ONES, ONES, ONES);
      tick(50);
      checkOutput("to_fail_sticky", 32'(bus.calib_fail), 32'd1);
      checkOutput("to_fail_lock_req", 32'(bus.ms_rx_dcc_dll_lock_req), 32'd0);
      checkOutput("to_fail_conf_done", 32'(bus.i_conf_done), 32'd0);
      checkOutput("to_fail_mac_rdy", 32'(bus.ns_mac_rdy), 32'd0);
`else
      $display("[TB] scenario: slave lock never arrives, unbounded wait");
      applyStimulus(1'b1, ONES, '0, '0, ONES, ONES);
      resetDut();
      tick(1500);
      checkOutput("nto_lock_req_held", 32'(bus.ms_tx_dcc_dll_lock_req), 32'h00FFFFFF);
      checkOutput("nto_no_fail", 32'(bus.calib_fail), 32'd0);
      checkOutput("nto_retry_zero", 32'(bus.retry_cnt), 32'd0);
`endif

      $display("[TB] scenario: slave lock on last cycle before timeout");
      applyStimulus(1'b1, ONES, '0, '0, '0, '0);
      resetDut();
      tick(4);
      checkOutput("late_lock_first_req", 32'(bus.ms_rx_dcc_dll_lock_req), 32'h00FFFFFF);
      tick(TMO - 1);
      applyStimulus(1'b1, ONES, ONES, ONES, '0, '0);
      tick(1);
      checkOutput("late_lock_adapter_rstn", 32'(bus.ns_adapter_rstn), 32'h00FFFFFF);
      checkOutput("late_lock_req_held", 32'(bus.ms_tx_dcc_dll_lock_req), 32'h00FFFFFF);
      checkOutput("late_lock_retry", 32'(bus.retry_cnt), 32'd0);

      $display("[TB] scenario: one-cycle transfer-enable drop on link");
      applyStimulus(1'b1, ONES, ONES, ONES, ONES, ONES);
      resetDut();
      tick(8);
      checkOutput("drop_link_up", 32'(bus.calib_done), 32'd1);
      applyStimulus(1'b1, ONES, ONES, ONES, ONES, 24'hFFFFDF);
      tick(1);
      applyStimulus(1'b1, ONES, ONES, ONES, ONES, ONES);
      low_run = 0;
      while (bus.ms_tx_transfer_en == '0 && bus.ms_rx_dcc_dll_lock_req == '0 && low_run < 100) begin
         low_run++;
         tick(1);
      end
      checkOutput("drop_low_cycles", 32'(low_run), 32'd16);
      checkOutput("drop_retry_cnt", 32'(bus.retry_cnt), 32'(RETRY_AFTER_DROP));
      relink = 0;
      while (!bus.calib_done && relink < 20) begin
         relink++;
         tick(1);
      end
      checkOutput("drop_relink_cycles", 32'(relink), 32'd2);

      $display("[TB] scenario: reset during transfer-enable wait");
      applyStimulus(1'b1, ONES, ONES, ONES, '0, '0);
      resetDut();
      waited = 0;
      while (bus.ns_adapter_rstn != ONES && waited < 20) begin
         tick(1);
         waited++;
      end
      checkOutput("rst_reached_xfer_wait", 32'(waited < 20), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_lock_req", 32'(bus.ms_rx_dcc_dll_lock_req), 32'd0);
      checkOutput("rst_adapter_rstn", 32'(bus.ns_adapter_rstn), 32'd0);
      checkOutput("rst_conf_done", 32'(bus.i_conf_done), 32'd0);
      checkOutput("rst_mac_rdy", 32'(bus.ns_mac_rdy), 32'd0);
      tick(2);
      applyStimulus(1'b1, ONES, ONES, ONES, ONES, ONES);
      rst_n = 1'b1;
      checkBringUp("rerun");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
